// File: rtl/icache_pkg.sv
// Shared instruction-cache definitions: geometry defaults, controller state
// encoding and a small address-layout helper.
package icache_pkg;

  localparam int ICACHE_INDEX_W = 6;
  localparam int ICACHE_TAG_W   = 22;
  localparam int ICACHE_WORDS   = 4;

  // Controller states; IDLE is zero so a cleared state register reads as IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_MISS   = 3'd2,
    ST_REFILL = 3'd3,
    ST_UPDATE = 3'd4,
    ST_DONE   = 3'd5,
    ST_FLUSH  = 3'd6
  } icache_state_e;

  // Number of address bits below the index: byte offset (2) plus word select.
  function automatic int line_off_w(input int words);
    return $clog2(words) + 2;
  endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Bundle of every signal between the icache controller and its neighbours:
// CPU fetch port, line-refill memory port, valid/tag RAM ports, status.
//
// Handshakes: the CPU raises CpuReq with a stable CpuAddr and holds both until
// the single-cycle CpuAck pulse. The controller raises MemReq with a stable
// MemAddr and holds both until memory returns the first MemValid beat; each
// further cycle with MemValid high carries exactly one more beat, and cycles
// with MemValid low are simply gaps.
interface icache_ctrl_if #(
  parameter int INDEX_W = icache_pkg::ICACHE_INDEX_W,
  parameter int TAG_W   = icache_pkg::ICACHE_TAG_W,
  parameter int WORDS   = icache_pkg::ICACHE_WORDS
);
  import icache_pkg::*;

  logic                     CpuReq;
  logic [31:0]              CpuAddr;
  logic                     CpuAck;
  logic                     Flush;
  logic                     FlushDone;
  logic                     MemReq;
  logic [31:0]              MemAddr;
  logic                     MemValid;
  logic                     DataWe;
  logic [$clog2(WORDS)-1:0] DataWordSel;
  logic [INDEX_W-1:0]       ValidAddr;
  logic                     ValidWrite;
  logic                     ValidIn;
  logic                     ValidOut;
  logic                     TagWrite;
  logic [TAG_W-1:0]         TagIn;
  logic [TAG_W-1:0]         TagOut;
  logic                     Busy;
  icache_state_e            DbgState;

  // Controller side.
  modport master (
    input  CpuReq, CpuAddr, Flush, MemValid, ValidOut, TagOut,
    output CpuAck, FlushDone, MemReq, MemAddr, DataWe, DataWordSel,
           ValidAddr, ValidWrite, ValidIn, TagWrite, TagIn, Busy, DbgState
  );

  // CPU, memory and RAM side.
  modport slave (
    output CpuReq, CpuAddr, Flush, MemValid, ValidOut, TagOut,
    input  CpuAck, FlushDone, MemReq, MemAddr, DataWe, DataWordSel,
           ValidAddr, ValidWrite, ValidIn, TagWrite, TagIn, Busy, DbgState
  );

endinterface

// File: rtl/icache_ctrl.sv
// Instruction-cache controller: lookup against external valid/tag RAMs,
// line refill from memory, and a full-array invalidate sweep on Flush.
// The valid/tag RAMs have a one-cycle registered read, so the lookup index is
// presented straight from CpuAddr in IDLE and the compare happens in LOOKUP.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int TAG_W   = ICACHE_TAG_W,
  parameter int WORDS   = ICACHE_WORDS
) (
  input  logic         Clk,
  input  logic         Reset,
  icache_ctrl_if.master bus
);

  localparam int WORD_W = $clog2(WORDS);
  localparam int OFF_W  = line_off_w(WORDS);
  localparam int LINE_W = 32 - OFF_W;
  localparam logic [WORD_W-1:0]  BEAT_LAST  = WORD_W'(WORDS - 1);
  localparam logic [INDEX_W-1:0] INDEX_LAST = {INDEX_W{1'b1}};

  icache_state_e      r_state;
  logic [LINE_W-1:0]  r_line;        // latched CpuAddr above the line offset
  logic [WORD_W-1:0]  r_beat;
  logic [INDEX_W-1:0] r_flush_cnt;
  logic               r_flush_pend;
  logic               r_armed;       // low only in the first IDLE cycle after reset

  logic               w_idle_live;
  logic               w_flush_go;
  logic               w_accept;
  logic               w_hit;
  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_index;

  logic               w_cpu_ack;
  logic               w_flush_done;
  logic               w_mem_req;
  logic [31:0]        w_mem_addr;
  logic               w_data_we;
  logic [WORD_W-1:0]  w_word_sel;
  logic [INDEX_W-1:0] w_valid_addr;
  logic               w_valid_write;
  logic               w_valid_in;
  logic               w_tag_write;
  logic [TAG_W-1:0]   w_tag_in;
  logic               w_busy;
  icache_state_e      w_dbg_state;

  assign w_tag       = r_line[INDEX_W +: TAG_W];
  assign w_index     = r_line[INDEX_W-1:0];
  assign w_idle_live = (r_state == ST_IDLE) && r_armed;
  assign w_flush_go  = bus.Flush || r_flush_pend;
  assign w_accept    = w_idle_live && !w_flush_go && bus.CpuReq;
  assign w_hit       = bus.ValidOut && (bus.TagOut == w_tag);

  // Controller state, address latch, refill beat and flush sweep counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_line       <= '0;
      r_beat       <= '0;
      r_flush_cnt  <= '0;
      r_flush_pend <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      // A flush that cannot start right now is remembered; repeats collapse.
      if (bus.Flush && !w_idle_live) r_flush_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_idle_live && w_flush_go) begin
            r_state      <= ST_FLUSH;
            r_flush_cnt  <= '0;
            r_flush_pend <= 1'b0;
          end else if (w_accept) begin
            r_line  <= bus.CpuAddr[31:OFF_W];
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          r_beat  <= '0;
          r_state <= w_hit ? ST_IDLE : ST_MISS;
        end
        ST_MISS: begin
          if (bus.MemValid) begin
            r_beat  <= r_beat + 1'b1;
            r_state <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (bus.MemValid) begin
            if (r_beat == BEAT_LAST) begin
              r_beat  <= '0;
              r_state <= ST_UPDATE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        ST_UPDATE: r_state <= ST_DONE;
        ST_DONE:   r_state <= ST_IDLE;
        ST_FLUSH: begin
          if (r_flush_cnt == INDEX_LAST) begin
            r_flush_cnt <= '0;
            r_state     <= ST_IDLE;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output decode from the state register; everything is forced low in reset.
  always_comb begin
    w_cpu_ack     = 1'b0;
    w_flush_done  = 1'b0;
    w_mem_req     = 1'b0;
    w_mem_addr    = '0;
    w_data_we     = 1'b0;
    w_word_sel    = '0;
    w_valid_addr  = '0;
    w_valid_write = 1'b0;
    w_valid_in    = 1'b0;
    w_tag_write   = 1'b0;
    w_tag_in      = '0;
    w_busy        = 1'b0;
    w_dbg_state   = ST_IDLE;
    if (!Reset) begin
      w_busy      = (r_state != ST_IDLE);
      w_dbg_state = r_state;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) w_valid_addr = bus.CpuAddr[OFF_W +: INDEX_W];
        end
        ST_LOOKUP: w_cpu_ack = w_hit;
        ST_MISS: begin
          w_mem_req  = 1'b1;
          w_mem_addr = {r_line, {OFF_W{1'b0}}};
          w_data_we  = bus.MemValid;
          w_word_sel = r_beat;
        end
        ST_REFILL: begin
          w_data_we  = bus.MemValid;
          w_word_sel = r_beat;
        end
        ST_UPDATE: begin
          w_valid_addr  = w_index;
          w_valid_write = 1'b1;
          w_valid_in    = 1'b1;
          w_tag_write   = 1'b1;
          w_tag_in      = w_tag;
        end
        ST_DONE: w_cpu_ack = 1'b1;
        ST_FLUSH: begin
          w_valid_addr  = r_flush_cnt;
          w_valid_write = 1'b1;
          w_flush_done  = (r_flush_cnt == INDEX_LAST);
        end
        default: ;
      endcase
    end
  end

  assign bus.CpuAck      = w_cpu_ack;
  assign bus.FlushDone   = w_flush_done;
  assign bus.MemReq      = w_mem_req;
  assign bus.MemAddr     = w_mem_addr;
  assign bus.DataWe      = w_data_we;
  assign bus.DataWordSel = w_word_sel;
  assign bus.ValidAddr   = w_valid_addr;
  assign bus.ValidWrite  = w_valid_write;
  assign bus.ValidIn     = w_valid_in;
  assign bus.TagWrite    = w_tag_write;
  assign bus.TagIn       = w_tag_in;
  assign bus.Busy        = w_busy;
  assign bus.DbgState    = w_dbg_state;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: hit, miss with beat gaps, flush sweep,
// flush during refill, flush racing a request, and reset mid-refill.
module tb_icache_ctrl;
  import icache_pkg::*;

  localparam int INDEX_W = 6;
  localparam int TAG_W   = 22;
  localparam int WORDS   = 4;
  localparam int MAX_CYC = 200;

  logic Clk;
  logic Reset;

  icache_ctrl_if #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .WORDS(WORDS)) bus ();

  icache_ctrl #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .WORDS(WORDS)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- valid/tag RAM model (registered read) ----------------
  logic             valid_mem [0:(1<<INDEX_W)-1];
  logic [TAG_W-1:0] tag_mem   [0:(1<<INDEX_W)-1];
  logic             pre_we;
  logic [INDEX_W-1:0] pre_idx;
  logic [TAG_W-1:0] pre_tag;

  always @(posedge Clk) begin
    bus.ValidOut <= valid_mem[bus.ValidAddr];
    bus.TagOut   <= tag_mem[bus.ValidAddr];
    if (Reset) begin
      for (int i = 0; i < (1<<INDEX_W); i++) valid_mem[i] <= 1'b0;
    end else begin
      if (bus.ValidWrite) valid_mem[bus.ValidAddr] <= bus.ValidIn;
      if (bus.TagWrite)   tag_mem[bus.ValidAddr]   <= bus.TagIn;
      if (pre_we) begin
        valid_mem[pre_idx] <= 1'b1;
        tag_mem[pre_idx]   <= pre_tag;
      end
    end
  end

  // ---------------- monitor (sampled on falling edge) ----------------
  int          cyc;
  int          ack_n, memreq_n, upd_n, upd_vin0_n, fw_vin1_n;
  logic [31:0] last_memaddr;
  logic [31:0] last_upd_addr, last_upd_tag;
  logic [31:0] beat_q[$];
  logic [31:0] memreq_cyc_q[$];
  logic [31:0] fw_addr_q[$];
  logic [31:0] fw_cyc_q[$];
  logic [31:0] fd_cyc_q[$];

  initial begin
    cyc = 0; ack_n = 0; memreq_n = 0; upd_n = 0; upd_vin0_n = 0; fw_vin1_n = 0;
    last_memaddr = '0; last_upd_addr = '0; last_upd_tag = '0;
  end

  always @(negedge Clk) begin
    cyc++;
    if (bus.CpuAck) ack_n++;
    if (bus.MemReq) begin
      memreq_n++;
      last_memaddr = bus.MemAddr;
      memreq_cyc_q.push_back(32'(cyc));
    end
    if (bus.DataWe) beat_q.push_back(32'(bus.DataWordSel));
    if (bus.ValidWrite && bus.TagWrite) begin
      upd_n++;
      last_upd_addr = 32'(bus.ValidAddr);
      last_upd_tag  = 32'(bus.TagIn);
      if (!bus.ValidIn) upd_vin0_n++;
    end
    if (bus.ValidWrite && !bus.TagWrite) begin
      fw_addr_q.push_back(32'(bus.ValidAddr));
      fw_cyc_q.push_back(32'(cyc));
      if (bus.ValidIn) fw_vin1_n++;
    end
    if (bus.FlushDone) fd_cyc_q.push_back(32'(cyc));
  end

  // ---------------- scoreboard ----------------
  int          n_total, n_bad;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs_now();
    return {bus.CpuAck, bus.FlushDone, bus.MemReq, bus.DataWe,
            bus.ValidWrite, bus.TagWrite, bus.ValidIn, bus.Busy};
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"},   32'(outs_now()), 32'h0);
    check({tag, "_maddr"}, bus.MemAddr, 32'h0);
    check({tag, "_fields"}, {2'b00, bus.TagIn, bus.ValidAddr, bus.DataWordSel}, 32'h0);
    check({tag, "_state"}, 32'(bus.DbgState), 32'(ST_IDLE));
  endtask

  // ---------------- drivers ----------------
  // Issue one CPU request and act as memory: pat[k] is MemValid for the k-th
  // cycle counted from the first cycle MemReq is seen. Returns the number of
  // cycles from the request cycle (counted as 1) to the ack cycle.
  task automatic serve_req(input logic [31:0] addr, input logic [15:0] pat,
                           input int flush_at, input bit flush_first,
                           output int lat, output int beat_cyc);
    int k, beats;
    bit started, got;
    k = 0; beats = 0; started = 1'b0; got = 1'b0; lat = 0;
    bus.CpuReq  = 1'b1;
    bus.CpuAddr = addr;
    bus.Flush   = flush_first;
    for (int c = 1; c <= MAX_CYC && !got; c++) begin
      if (c > 1) begin
        @(posedge Clk); #1;
        bus.Flush = 1'b0;
      end
      if (bus.MemReq) started = 1'b1;
      bus.MemValid = 1'b0;
      if (started && beats < WORDS && k < 16) begin
        bus.MemValid = pat[k];
        if (pat[k]) beats++;
        bus.Flush = (k == flush_at);
        k++;
      end
      @(negedge Clk);
      if (bus.CpuAck) begin
        got = 1'b1;
        lat = c;
      end
    end
    beat_cyc = k;
    check("ack_seen", 32'(got), 32'd1);
    @(posedge Clk); #1;
    bus.CpuReq   = 1'b0;
    bus.MemValid = 1'b0;
    bus.Flush    = 1'b0;
  endtask

  task automatic wait_fd(input int fd0, input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < MAX_CYC && !ok; c++) begin
      @(posedge Clk); #1;
      if (fd_cyc_q.size() > fd0) ok = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  logic [31:0] a_hit, a_miss, a_f12, a_r20;
  int lat, bc, m0, u0, a0, b0, fw0, fd0, vin0, errs;
  bit ok;

  initial begin
    n_total = 0; n_bad = 0;
    a_hit  = {22'h1ABCD, 6'd5,  2'd2, 2'd1};
    a_miss = {22'h2F00F, 6'd9,  2'd3, 2'd2};
    a_f12  = {22'h00123, 6'd12, 2'd1, 2'd0};
    a_r20  = {22'h3C0DE, 6'd20, 2'd0, 2'd3};
    Reset = 1'b1;
    bus.CpuReq = 1'b0; bus.CpuAddr = '0; bus.Flush = 1'b0; bus.MemValid = 1'b0;
    pre_we = 1'b0; pre_idx = '0; pre_tag = '0;

    // Reset: outputs quiet during reset and in the first IDLE cycle after.
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_quiet("rst_hi");
    @(posedge Clk); #1;
    Reset   = 1'b0;
    pre_we  = 1'b1;
    pre_idx = 6'd5;
    pre_tag = 22'h1ABCD;
    @(negedge Clk);
    check_quiet("rst_first_idle");
    @(posedge Clk); #1;
    pre_we = 1'b0;

    // Hit on preloaded line 5.
    m0 = memreq_n; u0 = upd_n;
    serve_req(a_hit, 16'h0000, -1, 1'b0, lat, bc);
    check("hit_lat", 32'(lat), 32'd2);
    check("hit_no_memreq", 32'(memreq_n - m0), 32'd0);
    check("hit_no_update", 32'(upd_n - u0), 32'd0);

    // Miss on index 9, one-cycle gap after the first beat.
    m0 = memreq_n; u0 = upd_n; b0 = beat_q.size();
    serve_req(a_miss, 16'h001D, -1, 1'b0, lat, bc);
    check("miss_lat", 32'(lat), 32'd9);
    check("miss_beat_cycles", 32'(bc), 32'd5);
    check("miss_memreq_cycles", 32'(memreq_n - m0), 32'd1);
    check("miss_memaddr", last_memaddr, {22'h2F00F, 6'd9, 4'd0});
    exp_q.delete();
    for (int i = 0; i < WORDS; i++) exp_q.push_back(32'(i));
    check("miss_beat_count", 32'(beat_q.size() - b0), 32'(exp_q.size()));
    errs = 0;
    for (int i = 0; i < exp_q.size() && b0 + i < beat_q.size(); i++)
      if (beat_q[b0 + i] !== exp_q[i]) errs++;
    check("miss_word_sel_seq", 32'(errs), 32'd0);
    check("miss_update_writes", 32'(upd_n - u0), 32'd1);
    check("miss_update_index", last_upd_addr, 32'd9);
    check("miss_update_tag", last_upd_tag, 32'h2F00F);
    check("miss_update_validin", 32'(upd_vin0_n), 32'd0);

    // Refilled line now hits.
    m0 = memreq_n;
    serve_req(a_miss, 16'h0000, -1, 1'b0, lat, bc);
    check("rehit_lat", 32'(lat), 32'd2);
    check("rehit_no_memreq", 32'(memreq_n - m0), 32'd0);

    // Flush from IDLE: 64 invalidating writes over indices 0..63.
    fw0 = fw_addr_q.size(); fd0 = fd_cyc_q.size(); vin0 = fw_vin1_n;
    bus.Flush = 1'b1;
    @(posedge Clk); #1;
    bus.Flush = 1'b0;
    wait_fd(fd0, "flush");
    check("flush_write_count", 32'(fw_addr_q.size() - fw0), 32'd64);
    exp_q.delete();
    for (int i = 0; i < (1<<INDEX_W); i++) exp_q.push_back(32'(i));
    errs = 0;
    for (int i = 0; i < exp_q.size() && fw0 + i < fw_addr_q.size(); i++)
      if (fw_addr_q[fw0 + i] !== exp_q[i]) errs++;
    check("flush_addr_seq", 32'(errs), 32'd0);
    check("flush_validin_zero", 32'(fw_vin1_n - vin0), 32'd0);
    check("flush_done_pulses", 32'(fd_cyc_q.size() - fd0), 32'd1);
    if (fd_cyc_q.size() > fd0 && fw_cyc_q.size() > fw0)
      check("flush_done_cycle", fd_cyc_q[fd0] - fw_cyc_q[fw0] + 1, 32'd64);
    else
      check("flush_done_cycle_present", 32'd0, 32'd1);

    // Line 5 was invalidated, so the old hit address now misses.
    m0 = memreq_n;
    serve_req(a_hit, 16'h000F, -1, 1'b0, lat, bc);
    check("postflush_lat", 32'(lat), 32'd8);
    check("postflush_memreq", 32'(memreq_n - m0), 32'd1);

    // Flush during REFILL: refill finishes and acks, flush runs next.
    u0 = upd_n; fw0 = fw_addr_q.size(); fd0 = fd_cyc_q.size();
    serve_req(a_f12, 16'h000F, 2, 1'b0, lat, bc);
    check("fdr_lat", 32'(lat), 32'd8);
    check("fdr_update_writes", 32'(upd_n - u0), 32'd1);
    check("fdr_idle_after_ack", 32'(bus.DbgState), 32'(ST_IDLE));
    @(posedge Clk); #1;
    check("fdr_flush_started", 32'(bus.DbgState), 32'(ST_FLUSH));
    wait_fd(fd0, "fdr");
    check("fdr_flush_writes", 32'(fw_addr_q.size() - fw0), 32'd64);

    // Flush and request together: flush first, then the lookup misses.
    fd0 = fd_cyc_q.size(); fw0 = fw_addr_q.size(); m0 = memreq_cyc_q.size();
    serve_req(a_f12, 16'h000F, -1, 1'b1, lat, bc);
    check("race_lat", 32'(lat), 32'd73);
    check("race_flush_writes", 32'(fw_addr_q.size() - fw0), 32'd64);
    if (fd_cyc_q.size() > fd0 && memreq_cyc_q.size() > m0)
      check("race_flush_before_miss", 32'(fd_cyc_q[fd0] < memreq_cyc_q[m0]), 32'd1);
    else
      check("race_events_present", 32'd0, 32'd1);

    // Reset after the second refill beat.
    u0 = upd_n; a0 = ack_n;
    bus.CpuReq = 1'b1; bus.CpuAddr = a_r20;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(posedge Clk); #1;
      if (bus.MemReq) ok = 1'b1;
    end
    check("rst_mid_memreq_seen", 32'(ok), 32'd1);
    bus.MemValid = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    bus.MemValid = 1'b0;
    bus.CpuReq   = 1'b0;
    Reset        = 1'b1;
    @(negedge Clk);
    check_quiet("rst_mid_hi");
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("rst_mid_idle", 32'(bus.DbgState), 32'(ST_IDLE));
    check("rst_mid_memreq_low", 32'(bus.MemReq), 32'd0);
    @(negedge Clk);
    check_quiet("rst_mid_first_idle");
    check("rst_mid_no_update", 32'(upd_n - u0), 32'd0);
    check("rst_mid_no_ack", 32'(ack_n - a0), 32'd0);
    @(posedge Clk); #1;
    m0 = memreq_n; u0 = upd_n;
    serve_req(a_r20, 16'h000F, -1, 1'b0, lat, bc);
    check("after_rst_lat", 32'(lat), 32'd8);
    check("after_rst_memaddr", last_memaddr, {22'h3C0DE, 6'd20, 4'd0});
    check("after_rst_update", 32'(upd_n - u0), 32'd1);
    check("after_rst_update_index", last_upd_addr, 32'd20);

    repeat (2) @(posedge Clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global time bound in case a wait escapes its cycle budget.
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have parameter INDEX_W, 6, index width (2^INDEX_W lines).
REQ-002 SHALL have parameter TAG_W, 22, tag width.
REQ-003 SHALL have parameter WORDS, 4, 32-bit words per line (power of 2, >=2).
REQ-004 SHALL have port Clk input 1, clock; all logic on rising edge.
REQ-005 SHALL have port Reset input 1, synchronous, active-high reset.
REQ-006 SHALL have ports CpuReq input 1, held until ack; CpuAddr input 32, byte address, stable while CpuReq.
REQ-007 SHALL have port CpuAck output 1, one-cycle completion pulse.
REQ-008 SHALL have ports Flush input 1, invalidate-all pulse; FlushDone output 1, one-cycle pulse.
REQ-009 SHALL have ports MemReq output 1; MemAddr output 32, line-aligned; MemValid input 1, one data beat per cycle asserted.
REQ-010 SHALL have ports DataWe output 1; DataWordSel output $clog2(WORDS), refill word index.
REQ-011 SHALL have ports ValidAddr output INDEX_W; ValidWrite output 1; ValidIn output 1; ValidOut input 1, registered read of ValidAddr.
REQ-012 SHALL have ports TagWrite output 1; TagIn output TAG_W; TagOut input TAG_W, registered read.
REQ-013 SHALL have port Busy output 1, high in every state except IDLE.

Function
REQ-014 SHALL split CpuAddr: [1:0] byte, next $clog2(WORDS) bits word, next INDEX_W bits index, next TAG_W bits tag (22+6+2+2=32 at defaults).
REQ-015 SHALL implement states IDLE, LOOKUP, MISS, REFILL, UPDATE, DONE, FLUSH.
REQ-016 SHALL in IDLE, with Flush or a pending flush, enter FLUSH; else with CpuReq, latch CpuAddr, drive ValidAddr=index, enter LOOKUP.
REQ-017 SHALL in LOOKUP compare ValidOut and TagOut against the latched tag: hit -> CpuAck=1 that cycle, then IDLE (hit latency 2 cycles from CpuReq sample); miss -> MISS.
REQ-018 SHALL in MISS assert MemReq with MemAddr = latched address with word/byte bits zeroed, holding both until the first MemValid, then enter REFILL.
REQ-019 SHALL assert DataWe=MemValid in MISS/REFILL with DataWordSel = beat counter (0..WORDS-1), counter incrementing only on MemValid; MemValid gaps stall without error.
REQ-020 SHALL on the MemValid of beat WORDS-1 enter UPDATE; MemReq deasserts after the first beat.
REQ-021 SHALL in UPDATE assert ValidWrite=1, ValidIn=1, TagWrite=1, TagIn=latched tag, ValidAddr=latched index for exactly one cycle, then DONE.
REQ-022 SHALL in DONE pulse CpuAck for one cycle, then IDLE (miss latency = 2 + beat cycles + 2).
REQ-023 SHALL in FLUSH sweep index counter 0..2^INDEX_W-1, one per cycle, with ValidWrite=1, ValidIn=0, TagWrite=0; after the last index pulse FlushDone and enter IDLE (2^INDEX_W cycles).
REQ-024 SHALL record a Flush arriving outside IDLE as pending, serviced at the next IDLE before any CpuReq; multiple pending flushes collapse to one.
REQ-025 SHALL give Flush priority over CpuReq when both arrive in IDLE; the request waits, CpuReq stays high.
REQ-026 SHALL keep CpuAck, DataWe, ValidWrite, TagWrite, MemReq, FlushDone low in every state/cycle not listed above.

Reset
REQ-027 SHALL on Reset enter IDLE and clear beat counter, flush counter, pending-flush flag and latched address.
REQ-028 SHALL drive all outputs 0 while Reset is high and in the first IDLE cycle after.
REQ-029 SHALL on Reset mid-refill or mid-flush abandon the operation without any further ValidWrite/TagWrite/CpuAck; valid-array clearing is the valid RAM's own reset.

Structure
REQ-030 SHALL take INDEX_W/TAG_W/WORDS defaults and the state enum from the shared cache package (icache_pkg).
REQ-031 SHALL be one module; no sub-module required.

Verification
REQ-032 SHALL test hit: preload line 5 valid, tag 0x1ABCD; CpuReq addr with that tag/index 5 -> CpuAck 2 cycles later, no MemReq.
REQ-033 SHALL test miss: invalid index 9 -> MemAddr line-aligned, 4 beats with one-cycle gap after beat 1 -> DataWordSel 0,1,2,3, single UPDATE write, CpuAck in DONE.
REQ-034 SHALL test flush: Flush in IDLE -> 64 ValidWrite cycles, ValidIn=0, addresses 0..63, FlushDone at cycle 64.
REQ-035 SHALL test Flush during REFILL -> refill completes and acks, FLUSH starts next IDLE; simultaneous Flush+CpuReq -> flush first, then lookup misses.
REQ-036 SHALL test Reset after beat 2 of refill -> IDLE next cycle, no UPDATE writes, MemReq low, subsequent request works.
